// File: rtl/grad_pkg.sv
// grad_pkg: shared state encoding and sizing constants for the gradient DAC sequencer
package grad_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
  localparam int NCH = 4;
  localparam int CH_W = 24;
  localparam int MIN_INTERVAL_DEF = 8;
endpackage

// File: rtl/grad_interval_timer.sv
// grad_interval_timer: loadable down-counter that ticks at zero and reloads its period
module grad_interval_timer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic        tick
);
  logic [15:0] cnt, rld;
  assign tick = en && cnt == 16'd0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      rld <= '0;
    end else if (load) begin
      cnt <= load_val;
      rld <= load_val;
    end else if (en) begin
      cnt <= tick ? rld : cnt - 16'd1;
    end
  end
endmodule

// File: rtl/grad_dac_sequencer.sv
// grad_dac_sequencer: fetches four channel words per sample from BRAM and issues them
// to the DAC serialiser on a programmable tick, counting ticks that could not be honoured
module grad_dac_sequencer
  import grad_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int MIN_INTERVAL = MIN_INTERVAL_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [15:0]       interval_i,
  input  logic [ADDR_W-3:0] last_idx_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_o,
  input  logic [31:0]       mem_data_i,
  output logic [CH_W-1:0]   datax_o,
  output logic [CH_W-1:0]   datay_o,
  output logic [CH_W-1:0]   dataz_o,
  output logic [CH_W-1:0]   dataz2_o,
  output logic              valid_o,
  input  logic              busy_i,
  output logic              running_o,
  output logic              done_o,
  output logic [ADDR_W-3:0] sample_idx_o,
  output logic [15:0]       underrun_cnt_o
);
  localparam int IW = ADDR_W - 2;
  state_t state, state_nxt;
  logic [IW-1:0] idx, last_idx;
  logic loop_r;
  logic [2:0] fcnt;
  logic [CH_W-1:0] stage [NCH];
  logic [15:0] ival, ival_m1;
  logic active, tick, start_ok, abort, issue, miss, last, finish;
  assign active = state != IDLE;
  assign start_ok = !active && start_i && !stop_i;
  assign abort = active && stop_i;
  assign ival = interval_i < 16'(MIN_INTERVAL) ? 16'(MIN_INTERVAL) : interval_i;
  assign ival_m1 = ival - 16'd1;
  assign last = idx == last_idx;
  assign issue = tick && !stop_i && state == READY && !busy_i;
  assign miss = tick && !stop_i && (state == FETCH || (state == READY && busy_i));
  assign finish = issue && last && !loop_r;
  assign running_o = active;
  assign sample_idx_o = idx;
  assign mem_en_o = state == FETCH && !fcnt[2];
  assign mem_addr_o = mem_en_o ? {idx, fcnt[1:0]} : '0;
  grad_interval_timer u_timer (
    .clk,
    .rstn,
    .load(start_ok),
    .en(active),
    .load_val(ival_m1),
    .tick
  );
  always_comb begin
    state_nxt = abort ? IDLE :
                start_ok ? FETCH :
                (state == FETCH && fcnt[2]) ? READY :
                issue ? (finish ? IDLE : FETCH) : state;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  end
  // fcnt counts fetch cycles; word k lands one cycle after its address, hence the -1 slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
      last_idx <= '0;
      loop_r <= 1'b0;
      fcnt <= '0;
      stage <= '{default: '0};
      datax_o <= '0;
      datay_o <= '0;
      dataz_o <= '0;
      dataz2_o <= '0;
      valid_o <= 1'b0;
      done_o <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      valid_o <= issue;
      done_o <= finish;
      if (start_ok) begin
        last_idx <= last_idx_i;
        loop_r <= loop_i;
        idx <= '0;
        fcnt <= '0;
        underrun_cnt_o <= '0;
      end
      if (state == FETCH && !abort) begin
        fcnt <= fcnt + 3'd1;
        if (fcnt != 3'd0) stage[2'(fcnt - 3'd1)] <= mem_data_i[CH_W-1:0];
      end
      if (issue) begin
        datax_o <= stage[0];
        datay_o <= stage[1];
        dataz_o <= stage[2];
        dataz2_o <= stage[3];
        idx <= last ? '0 : idx + IW'(1);
        fcnt <= '0;
      end
      if (miss && underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end
endmodule
